// File: rtl/ram8x16_pkg.sv
// Shared constants and FSM encoding for the
// eight-word 16-bit register store.
package ram8x16_pkg;

   localparam int WORD_W = 16;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_t;

endpackage

// File: rtl/ram8x16_reg.sv
// 16-bit load-enable register, one per word
// of the eight-word store.
module ram8x16_reg
   import ram8x16_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [WORD_W-1:0] d,
   output logic [WORD_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/ram8x16.sv
// Eight 16-bit words, one write per cycle,
// combinational read and a multi-cycle clear sweep.
module ram8x16
   import ram8x16_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] in,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   input  logic              clear,
   output logic [WORD_W-1:0] out,
   output logic              busy
);

   state_t              state;
   state_t              state_n;
   logic [ADDR_W-1:0]   ptr;
   logic [ADDR_W-1:0]   ptr_n;
   logic                sweeping;
   logic                load_ok;
   logic [DEPTH-1:0]    dec;
   logic [DEPTH-1:0]    we;
   logic [WORD_W-1:0]   wdata;
   logic [WORD_W-1:0]   words [DEPTH];

   assign sweeping = (state == ST_SWEEP);
   assign busy     = sweeping;
   // clear wins over a load presented in the same idle cycle
   assign load_ok  = load & ~sweeping & ~clear;
   assign wdata    = sweeping ? '0 : in;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         ptr   <= '0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      unique case (state)
         ST_IDLE: begin
            if (clear) begin
               state_n = ST_SWEEP;
               ptr_n   = '0;
            end
         end
         ST_SWEEP: begin
            ptr_n = ptr + 3'd1;
            if (ptr == 3'd7)
               state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
            ptr_n   = '0;
         end
      endcase
   end

   always_comb begin
      dec = '0;
      dec[address] = 1'b1;
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      assign we[i] = (load_ok & dec[i])
                   | (sweeping & (ptr == ADDR_W'(i)));

      ram8x16_reg u_reg (
         .clk   (clk),
         .reset (reset),
         .load  (we[i]),
         .d     (wdata),
         .q     (words[i])
      );
   end

   always_comb begin
      out = words[address];
   end

endmodule

// File: tb/tb_ram8x16.sv
// Randomized and directed bench for ram8x16 with a
// queue-based scoreboard fed by an abstract model.
module tb_ram8x16;

   typedef struct {
      logic [15:0] out;
      logic        busy;
      logic [2:0]  addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] in = '0;
   logic [2:0]  address = '0;
   logic [15:0] out;
   logic        busy;

   logic [15:0] mem [8];
   bit          sweeping = 0;
   int          idx = 0;
   exp_t        sb [$];
   exp_t        e;
   int          vectors = 0;
   int          errors = 0;

   ram8x16 dut (
      .clk     (clk),
      .reset   (reset),
      .in      (in),
      .load    (load),
      .address (address),
      .clear   (clear),
      .out     (out),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic step(input logic r, input logic l,
                       input logic c, input logic [15:0] d,
                       input logic [2:0] a);
      @(negedge clk);
      reset = r; load = l; clear = c; in = d; address = a;
      @(posedge clk);
      if (r) begin
         foreach (mem[i]) mem[i] = 16'h0000;
         sweeping = 0;
         idx = 0;
      end else if (sweeping) begin
         mem[idx] = 16'h0000;
         idx++;
         if (idx == 8) begin
            sweeping = 0;
            idx = 0;
         end
      end else if (c) begin
         sweeping = 1;
         idx = 0;
      end else if (l) begin
         mem[a] = d;
      end
      sb.push_back('{mem[a], sweeping, a});
   endtask

   task automatic fill(input logic [15:0] v);
      for (int i = 0; i < 8; i++) step(0, 1, 0, v, 3'(i));
   endtask

   task automatic read_all();
      for (int i = 0; i < 8; i++) step(0, 0, 0, 16'hDEAD, 3'(i));
   endtask

   always @(posedge clk) begin
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         vectors++;
         if (out !== e.out || busy !== e.busy) begin
            errors++;
            $display("FAIL rd[%0d] out=%h busy=%b expected out=%h busy=%b",
                     e.addr, out, busy, e.out, e.busy);
         end
      end
   end

   initial begin
      step(1, 0, 0, 16'h0000, 3'd0);
      read_all();

      for (int i = 0; i < 7; i++)
         step(0, 1, 0, 16'(16'h1111 * (i + 1)), 3'(i));
      step(0, 1, 0, 16'hFFFF, 3'd7);
      read_all();
      read_all();

      fill(16'hA5A5);
      step(0, 0, 1, 16'h0000, 3'd3);
      repeat (9) step(0, 0, 0, 16'h0000, 3'd3);
      read_all();

      fill(16'hC3C3);
      step(0, 0, 1, 16'h0000, 3'd7);
      step(0, 0, 0, 16'h0000, 3'd7);
      step(0, 1, 0, 16'h1234, 3'd7);
      repeat (6) step(0, 0, 0, 16'h0000, 3'd7);
      step(0, 0, 0, 16'h0000, 3'd7);

      fill(16'h7777);
      step(0, 1, 1, 16'hBEEF, 3'd2);
      repeat (8) step(0, 0, 0, 16'h0000, 3'd2);
      step(0, 0, 0, 16'h0000, 3'd2);

      fill(16'h3C3C);
      repeat (10) step(0, 0, 1, 16'h0000, 3'd0);
      step(0, 1, 0, 16'h4242, 3'd1);
      repeat (8) step(0, 0, 0, 16'h0000, 3'd1);

      fill(16'h5A5A);
      step(0, 0, 1, 16'h0000, 3'd6);
      repeat (3) step(0, 0, 0, 16'h0000, 3'd6);
      step(1, 0, 0, 16'h0000, 3'd6);
      read_all();
      step(0, 1, 0, 16'h9876, 3'd5);
      step(0, 0, 0, 16'h0000, 3'd5);

      for (int n = 0; n < 400; n++) begin
         step(($urandom % 60) == 0,
              ($urandom % 2) == 0,
              ($urandom % 12) == 0,
              16'($urandom),
              3'($urandom));
      end

      repeat (3) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule

// File: doc/ram8x16.md
# ram8x16

Eight-word, 16-bit register storage block, the storage stage that directly feeds the 16-bit 8-way multiplexer on its read path. It holds eight 16-bit registers, writes one per cycle under a load strobe, and reads combinationally through the 8-way mux. A multi-cycle clear sweep zeroes all words without a full reset. It is the building block for the larger RAM64/RAM512 hierarchy.

## Interface
Parameters:
- None. Width is fixed at 16 and depth at 8, matching the 16-bit mux/register family.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high. Clears all words, FSM and pointer.
- in  input  16  write data.
- load  input  1  write strobe; accepted only when busy==0.
- address  input  3  word select for both write and read (0..7).
- clear  input  1  request a clear sweep; accepted only when busy==0.
- out  output  16  contents of word[address]; combinational read.
- busy  output  1  registered; high while the clear sweep runs.

## Operation
- Storage: word[0..7], each 16 bits.
- Reset at a rising edge:
  - all words become 0x0000, FSM goes to IDLE, ptr becomes 0, busy becomes 0.
  - out therefore reads 0x0000 for any address.
- Write: at a rising edge with load=1, busy=0, clear=0 and reset=0, word[address] <= in. Other words hold.
- Read: out = word[address] via the 8-way 16-bit mux. There is no read enable, and address changes are reflected immediately.
- FSM states are IDLE and SWEEP, with a 3-bit pointer ptr.
  - IDLE with clear=1 at an edge: go to SWEEP, ptr <= 0. A load in the same cycle is dropped (clear has priority).
  - SWEEP at each edge: word[ptr] <= 0 and ptr <= ptr+1.
  - When ptr==7: word[7] <= 0, ptr wraps to 0, go to IDLE.
- busy = (state == SWEEP), taken from the register, with no combinational path from clear.
- While busy=1: load is ignored and the target word is untouched. clear is ignored and the sweep is not restarted.
- out during a sweep shows live contents, so words below ptr already read 0.
- Reset mid-sweep: reset overrides everything, with the same result as the reset rule above. There is no partial-sweep residue.
- Reset has priority over clear and load in the same cycle.

## Timing
- Write latency: data written at edge E is visible on out immediately after E, provided address still selects that word.
- Read latency: 0 cycles, combinational from address and stored data.
- Clear sweep, with clear sampled at edge E0:
  - busy rises after E0.
  - Edges E1..E8 zero word0..word7 in order.
  - busy falls after E8, so busy is high for exactly 8 cycles.
  - The first accepted load or clear is at E9.
- Back-to-back clear requests: a clear held high through E8 starts a new sweep at E9.

## Structure
- Shared include header holds:
  - constants WORD_W=16, DEPTH=8, ADDR_W=3;
  - FSM state encodings ST_IDLE=0, ST_SWEEP=1.
- Sub-modules:
  - eight instances of the 16-bit load-enable register;
  - the 8-way 16-bit mux on the read path;
  - an 8-way demux decoding address into per-word load enables.
- The sweep FSM and ptr are local. Each word's enable is (load_ok & dec[i]) | (sweeping & ptr==i). Its data is 0 while sweeping, otherwise in.

## Test plan
- Reset, then read all addresses: out==0x0000 for address 0..7 and busy==0.
- Write 0x1111*(i+1) to word i (i=0..6) and 0xFFFF to word 7, then sweep address: each readback matches. Then with load=0 and in=0xDEAD, no word changes.
- Fill all words with 0xA5A5, pulse clear for 1 cycle:
  - busy is high for exactly 8 cycles;
  - reading address 3 shows 0xA5A5 until after E4, then 0x0000;
  - all words read 0 after E8.
- During a sweep, load=1 to address 7 with 0x1234 at E2: this is ignored, and word7 reads 0 after the sweep.
- clear=1 and load=1 (address 2, 0xBEEF) in the same IDLE cycle: the load is dropped, the sweep starts, and word2 reads 0x0000.
- Fill with 0x5A5A, start a sweep, assert reset at E4:
  - after that edge all words read 0, busy==0 and the FSM is IDLE;
  - a write at the next edge succeeds.
